// File: rtl/wheel_meas_uc.sv
// wheel_meas_uc: periodic snapshot/clear of wheel tick counters and valid/ready serialisation of the counts.
// Defining WHEEL_MEAS_SEQ_EN prefixes each burst with a header record carrying an 8-bit window sequence number.
module wheel_meas_uc #(
  parameter int N_WHEELS = 2,
  parameter int CW = 16,
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [N_WHEELS*CW-1:0] counts,
  output logic clr,
  output logic tx_valid,
  input  logic tx_ready,
  output logic [3:0] tx_id,
  output logic [CW-1:0] tx_data,
  output logic overrun,
  output logic busy
);
  localparam int TW = $clog2(PERIOD);
  localparam logic [3:0] LAST = 4'(N_WHEELS - 1);
`ifdef WHEEL_MEAS_SEQ_EN
  localparam logic [3:0] FIRST = 4'(N_WHEELS);
`else
  localparam logic [3:0] FIRST = 4'd0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, SNAP, SEND} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] idx;
  logic [N_WHEELS*CW-1:0] snap;
  logic [CW-1:0] wheel;
  logic pending, tick, xfer, done;
  assign tick = state != IDLE && timer == TW'(PERIOD - 1);
  assign xfer = state == SEND && tx_ready;
  assign done = xfer && idx == LAST;
  assign clr = state == SNAP;
  assign tx_valid = state == SEND;
  assign busy = state == SNAP || state == SEND;
  assign tx_id = idx;
  // The IDLE cycle that sees enable counts as timer step 0, so the window is exactly PERIOD long.
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = enable ? WAIT : IDLE;
    else if (state == WAIT) state_n = !enable ? IDLE : tick ? SNAP : WAIT;
    else if (state == SNAP) state_n = SEND;
    else if (done) state_n = !enable ? IDLE : (pending || tick) ? SNAP : WAIT;
    timer_n = (state_n == IDLE || timer == TW'(PERIOD - 1)) ? '0 : timer + 1'b1;
  end
  always_comb begin
    wheel = '0;
    for (int i = 0; i < N_WHEELS; i++) if (idx == 4'(i)) wheel = snap[i*CW +: CW];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      snap <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (state == SNAP) begin
        snap <= counts;
        idx <= FIRST;
      end else if (xfer) idx <= (done || idx == 4'(N_WHEELS)) ? '0 : idx + 1'b1;
      pending <= state == SEND && !done && (pending || tick);
      overrun <= overrun || (state == SEND && tick);
    end
  end
`ifdef WHEEL_MEAS_SEQ_EN
  logic [7:0] seq, hdr;
  // seq already counts the current window, so the header shows the value before that increment.
  assign hdr = seq - 8'd1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) seq <= '0;
    else if (state == SNAP) seq <= seq + 8'd1;
  end
  assign tx_data = (idx == FIRST) ? {{(CW-8){1'b0}}, hdr} : wheel;
`else
  assign tx_data = wheel;
`endif
endmodule

// File: doc/wheel_meas_uc.md
# wheel_meas_uc

Control unit that sequences periodic speed measurement for the wheel encoder interfaces of the Cyclone Cruiser. Every `PERIOD` clock cycles it snapshots and clears all per-wheel tick counters in one cycle. It then serialises the captured counts, one record per wheel, to the telemetry transmitter over a valid/ready handshake. It sits between the wheel interface datapaths, which own the counters, and the transmit path.

## Interface
- `N_WHEELS`, 2: number of wheel interfaces served (1..8).
- `CW`, 16: count width per wheel, two's complement (CW minus CWW ticks).
- `PERIOD`, 50000: measurement window length in clock cycles (≥ 4).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run measurement windows while high.
- `counts` in N_WHEELS*CW: concatenated wheel counts, wheel 0 in LSBs.
- `clr` out 1: one-cycle pulse that zeroes all wheel counters.
- `tx_valid` out 1: record available.
- `tx_ready` in 1: transmitter accepts record.
- `tx_id` out 4: record id, wheel index 0..N_WHEELS-1, or header id N_WHEELS.
- `tx_data` out CW: record payload.
- `overrun` out 1: sticky; a window tick arrived while a burst was still being sent.
- `busy` out 1: high in states SNAP and SEND.

## Operation
- States: IDLE, WAIT, SNAP, SEND.
- IDLE: timer held at 0. Moves to WAIT when `enable`=1.
- WAIT: timer counts 0..PERIOD-1 and wraps.
  - tick = timer==PERIOD-1.
  - On tick, moves to SNAP.
  - On `enable`=0, moves to IDLE.
- SNAP: lasts one cycle. `clr`=1. All `counts` are latched into an internal record buffer at the closing edge. Sets index=0, or the header slot if configured. Moves to SEND.
- SEND: `tx_valid`=1 with `tx_id`/`tx_data` for the current index.
  - On `tx_valid`&`tx_ready` at a rising edge, index increments.
  - After the last wheel is accepted: go to SNAP if a tick is pending; otherwise go to WAIT if `enable`=1, else IDLE.
- The timer keeps running in SNAP and SEND, so window boundaries never drift.
- A tick during SEND (including the cycle of the last transfer):
  - sets `overrun`=1 (sticky until reset);
  - sets pending.
  - Only one tick is stored; further ticks are lost and the counters keep accumulating.
- `enable` dropping in SNAP/SEND: the burst completes and no pending tick is served. Then IDLE.
- A counter edge in the `clr` cycle is lost by design; the counter gives clear priority.
- Payload is the raw signed count. No saturation in this block.

## Timing
- Reset values:
  - state IDLE, timer 0;
  - `clr`=0, `tx_valid`=0, `tx_id`=0, `tx_data`=0;
  - `overrun`=0, `busy`=0, pending=0.
- All outputs are registered or decoded from the state register only. No combinational path from `tx_ready` to any output.
- With the tick in cycle t: `clr` is high in cycle t+1, and the first `tx_valid` is high in cycle t+2.
- `tx_valid` never drops before its transfer. `tx_id` and `tx_data` are stable while `tx_valid`=1 and `tx_ready`=0.
- With `tx_ready` tied high, a burst takes N_WHEELS cycles (N_WHEELS+1 with a header).
- Back-to-back transfers are allowed: the next record is presented in the cycle after acceptance.
- Asynchronous reset mid-burst: the burst is abandoned and `tx_valid` drops immediately.

## Configuration
- `WHEEL_MEAS_SEQ_EN` defined:
  - an 8-bit window sequence counter increments in every SNAP and wraps 255→0;
  - each burst starts with a header record, `tx_id`=N_WHEELS, `tx_data`=sequence value zero-extended to CW bits;
  - the first window after reset carries sequence 0.
- Not defined: no header and no sequence counter. Bursts carry only wheel records.

## Test plan
- Basic window: PERIOD=10, N_WHEELS=2, `tx_ready`=1, counts {wheel1=-3, wheel0=5} → `clr` pulse 10 cycles after `enable` rises; records (0,5) then (1,0xFFFD) on consecutive cycles; repeats every 10 cycles.
- Backpressure: hold `tx_ready`=0 for 4 cycles on record 0 → `tx_valid` stays high; `tx_id`/`tx_data` stay stable; record 0 is transferred once, then record 1.
- Overrun: PERIOD=10, `tx_ready`=0 for 12 cycles → `overrun`=1 and stays 1; a second `clr` follows in the cycle after the last transfer.
- Enable drop: `enable`=0 during SEND → burst completes, then IDLE; no further `clr`; timer is 0 when `enable` rises again.
- Reset mid-burst: `reset` low while `tx_valid`=1 → all outputs reach reset values without a clock edge; after release, the first `clr` comes PERIOD cycles after `enable`.
- With `WHEEL_MEAS_SEQ_EN`: three windows → headers (2,0), (2,1), (2,2), each followed by the wheel records.
